// File: rtl/simple_processor_param.sv
// simple_processor_param: multi-cycle eight-register CPU with a parameterised datapath.
// Executes one 16-bit instruction per accepted run request. The ALU supports add, sub,
// and, or and xor. Move instructions take 2 cycles and ALU instructions take 4.
module simple_processor_param #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  run,
    input  logic [15:0]           DIN,
    output logic                  done,
    output logic                  busy,
    output logic                  illegal,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    input  logic [2:0]            dbg_sel,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    // Field view of the instruction word; imm[2:0] doubles as register Y when M=0.
    typedef struct packed {
        logic [2:0] op;
        logic       m;
        logic [2:0] x;
        logic [8:0] imm;
    } instr_t;

    state_t              state, state_nx;
    instr_t              ir;
    logic [7:0][W-1:0]   r;
    logic [W-1:0]        a, b, g;
    logic                z_pend, n_pend, c_pend;

    logic                ir_ld, ab_ld, g_ld, wr_en, flags_wr, done_nx, ill_nx;
    logic [W-1:0]        wr_data, op2, mvt_val, alu_res, b_eff;
    logic [W:0]          sum;
    logic                alu_c, is_sub;

    // Second operand: sign-extended immediate or register Y.
    assign op2      = ir.m ? {{(W-9){ir.imm[8]}}, ir.imm} : r[ir.imm[2:0]];
    assign mvt_val  = {ir.imm[7:0], {(W-8){1'b0}}};
    assign busy     = (state != IDLE);
    assign dbg_data = r[dbg_sel];

    // ALU: subtraction reuses the adder as A + ~B + 1 so carry means "no borrow".
    always_comb begin
        is_sub  = (ir.op == OP_SUB);
        b_eff   = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
        alu_res = sum[W-1:0];
        alu_c   = 1'b0;
        case (ir.op)
            OP_ADD, OP_SUB: begin alu_res = sum[W-1:0]; alu_c = sum[W]; end
            OP_AND:         alu_res = a & b;
            OP_OR:          alu_res = a | b;
            OP_XOR:         alu_res = a ^ b;
            default:        alu_res = sum[W-1:0];
        endcase
    end

    // State register; reset wins over everything, including a pending run.
    always_ff @(posedge clk_50MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_nx = state;
        ir_ld    = 1'b0;
        ab_ld    = 1'b0;
        g_ld     = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        flags_wr = 1'b0;
        done_nx  = 1'b0;
        ill_nx   = 1'b0;
        case (state)
            IDLE: if (run) begin ir_ld = 1'b1; state_nx = T1; end
            T1: begin
                case (ir.op)
                    OP_MV:  begin wr_en = 1'b1; wr_data = op2;     done_nx = 1'b1; state_nx = IDLE; end
                    OP_MVT: begin wr_en = 1'b1; wr_data = mvt_val; done_nx = 1'b1; state_nx = IDLE; end
                    OP_ILL: begin done_nx = 1'b1; ill_nx = 1'b1; state_nx = IDLE; end
                    default: begin ab_ld = 1'b1; state_nx = T2; end
                endcase
            end
            T2: begin g_ld = 1'b1; state_nx = T3; end
            T3: begin
                wr_en    = 1'b1;
                wr_data  = g;
                flags_wr = 1'b1;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: flags are computed with G and only become visible with done.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            ir      <= '0;
            r       <= '0;
            a       <= '0;
            b       <= '0;
            g       <= '0;
            z_pend  <= 1'b0;
            n_pend  <= 1'b0;
            c_pend  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (ir_ld) ir <= instr_t'(DIN);
            if (ab_ld) begin
                a <= r[ir.x];
                b <= op2;
            end
            if (g_ld) begin
                g      <= alu_res;
                z_pend <= (alu_res == '0);
                n_pend <= alu_res[W-1];
                c_pend <= alu_c;
            end
            if (wr_en) r[ir.x] <= wr_data;
            if (flags_wr) begin
                flag_z <= z_pend;
                flag_n <= n_pend;
                flag_c <= c_pend;
            end
            done    <= done_nx;
            illegal <= ill_nx;
        end
    end
endmodule

// File: tb/tb_simple_processor_param.sv
// Scoreboard bench: a 16-bit and a 32-bit instance share reset, DIN and dbg_sel.
// Drivers push expected results, and per-instance monitors check them on done.
module tb_simple_processor_param;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  run;
    logic [15:0] din;
    logic [2:0]  dbg_sel;
    logic [1:0]  done, busy, ill, fz, fn, fc;
    logic [15:0] d16;
    logic [31:0] d32;

    simple_processor_param #(.DATA_WIDTH(16)) u16 (
        .clk_50MHz(clk), .reset(reset), .run(run[0]), .DIN(din),
        .done(done[0]), .busy(busy[0]), .illegal(ill[0]),
        .flag_z(fz[0]), .flag_n(fn[0]), .flag_c(fc[0]),
        .dbg_sel(dbg_sel), .dbg_data(d16));

    simple_processor_param #(.DATA_WIDTH(32)) u32 (
        .clk_50MHz(clk), .reset(reset), .run(run[1]), .DIN(din),
        .done(done[1]), .busy(busy[1]), .illegal(ill[1]),
        .flag_z(fz[1]), .flag_n(fn[1]), .flag_c(fc[1]),
        .dbg_sel(dbg_sel), .dbg_data(d32));

    typedef struct {
        logic [63:0] val;
        logic        z, n, c, il;
        int          lat;
        int          t;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(string tag, exp_t e, logic [63:0] data, logic z, logic n, logic c, logic il);
        chk({tag, " data"}, data, e.val);
        chk({tag, " z"}, 64'(z), 64'(e.z));
        chk({tag, " n"}, 64'(n), 64'(e.n));
        chk({tag, " c"}, 64'(c), 64'(e.c));
        chk({tag, " illegal"}, 64'(il), 64'(e.il));
        chk({tag, " latency"}, 64'(cyc - e.t), 64'(e.lat));
    endtask

    // Monitors: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done[0] === 1'b1) begin
            if (q16.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w16 unexpected done at cycle %0d", cyc);
            end else check_entry("w16", q16.pop_front(), 64'(d16), fz[0], fn[0], fc[0], ill[0]);
        end
    end

    always @(negedge clk) begin
        if (done[1] === 1'b1) begin
            if (q32.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w32 unexpected done at cycle %0d", cyc);
            end else check_entry("w32", q32.pop_front(), 64'(d32), fz[1], fn[1], fc[1], ill[1]);
        end
    end

    // Queue the expectation and present the instruction; dbg_sel follows rX.
    task automatic push(int w, logic [15:0] instr, logic [63:0] val,
                        logic z, logic n, logic c, logic il, int lat);
        exp_t e;
        e.val = val; e.z = z; e.n = n; e.c = c; e.il = il; e.lat = lat; e.t = cyc;
        if (w == 0) q16.push_back(e);
        else        q32.push_back(e);
        din     = instr;
        dbg_sel = instr[11:9];
        run[w]  = 1'b1;
    endtask

    task automatic wait_done(int w);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (done[w] === 1'b1) seen = 1'b1;
        end
        chk($sformatf("w%0d done_seen", w), 64'(seen), 64'd1);
        #1;
    endtask

    task automatic issue(int w, logic [15:0] instr, logic [63:0] val,
                         logic z, logic n, logic c, logic il, int lat);
        push(w, instr, val, z, n, c, il, lat);
        @(posedge clk); #1;
        run[w] = 1'b0;
        wait_done(w);
    endtask

    initial begin
        reset = 1'b1; run = 2'b11; din = 16'h11FF; dbg_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("rst w%0d done", w), 64'(done[w]), 64'd0);
            chk($sformatf("rst w%0d busy", w), 64'(busy[w]), 64'd0);
            chk($sformatf("rst w%0d illegal", w), 64'(ill[w]), 64'd0);
            chk($sformatf("rst w%0d flags", w), {61'd0, fz[w], fn[w], fc[w]}, 64'd0);
        end
        run = 2'b00;
        for (int s = 0; s < 8; s++) begin
            dbg_sel = 3'(s);
            #1;
            chk($sformatf("rst r%0d w16", s), 64'(d16), 64'd0);
            chk($sformatf("rst r%0d w32", s), 64'(d32), 64'd0);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;

        // 16-bit: moves, ALU ops and flags, issued back to back.
        issue(0, 16'h11FF, 64'hFFFF, 0, 0, 0, 0, 2);   // mv r0,#-1
        issue(0, 16'h13FE, 64'hFFFE, 0, 0, 0, 0, 2);   // mv r1,#-2
        issue(0, 16'h4001, 64'hFFFD, 0, 1, 1, 0, 4);   // add r0,r1
        issue(0, 16'h6000, 64'h0000, 1, 0, 1, 0, 4);   // sub r0,r0
        issue(0, 16'h1200, 64'h0000, 1, 0, 1, 0, 2);   // mv r1,#0 keeps flags
        issue(0, 16'h5205, 64'h0005, 0, 0, 0, 0, 4);   // add r1,#5
        issue(0, 16'h14F0, 64'h00F0, 0, 0, 0, 0, 2);   // mv r2,#0xF0
        issue(0, 16'hD5FF, 64'hFF0F, 0, 1, 0, 0, 4);   // xor r2,#-1
        issue(0, 16'h8401, 64'h0005, 0, 0, 0, 0, 4);   // and r2,r1
        issue(0, 16'hB500, 64'hFF05, 0, 1, 0, 0, 4);   // or r2,#-256
        issue(0, 16'h7206, 64'hFFFF, 0, 1, 0, 0, 4);   // sub r1,#6 borrows
        issue(0, 16'hE000, 64'h0000, 0, 1, 0, 1, 2);   // illegal; r0 and flags intact

        // A run request while busy in T2 must be ignored.
        push(0, 16'h4001, 64'hFFFF, 0, 1, 0, 0, 4);    // add r0,r1 = 0 + 0xFFFF
        @(posedge clk); #1; run[0] = 1'b0;
        @(posedge clk); #1;
        chk("w16 busy in T2", 64'(busy[0]), 64'd1);
        run[0] = 1'b1; din = 16'h1001;                  // mv r0,#1 would clobber r0
        @(posedge clk); #1; run[0] = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);
        #1;

        // 32-bit: wide moves, mvt placement and carry out of bit 31.
        issue(1, 16'h17FF, 64'hFFFF_FFFF, 0, 0, 0, 0, 2); // mv r3,#-1
        issue(1, 16'h34A5, 64'hA500_0000, 0, 0, 0, 0, 2); // mvt r2,#0xA5
        issue(1, 16'h5601, 64'h0000_0000, 1, 0, 1, 0, 4); // add r3,#1 wraps
        issue(1, 16'h4402, 64'h4A00_0000, 0, 0, 1, 0, 4); // add r2,r2

        // Reset during T2 of an add: no done, and registers are cleared.
        din = 16'h4001; dbg_sel = 3'd0; run[0] = 1'b1;
        @(posedge clk); #1; run[0] = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("midrst busy", 64'(busy[0]), 64'd0);
        chk("midrst done", 64'(done[0]), 64'd0);
        chk("midrst r0", 64'(d16), 64'd0);
        dbg_sel = 3'd1; #1;
        chk("midrst r1", 64'(d16), 64'd0);
        @(negedge clk); #1;
        issue(0, 16'h5205, 64'h0005, 0, 0, 0, 0, 4);    // add r1,#5 after reset

        repeat (3) @(negedge clk);
        chk("q16 drained", 64'(q16.size()), 64'd0);
        chk("q32 drained", 64'(q32.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/simple_processor_param.md
# simple_processor_param

Parametrised successor to the 16-bit `simple_processor`: a multi-cycle, eight-register CPU that executes one externally supplied 16-bit instruction per `run` request. The datapath width is set by a parameter, and the ALU adds sub, and, or, xor and mvt (move-top). Results update status flags. A combinational debug read port exposes any register to the bench or an upstream test harness.

## Interface
- `DATA_WIDTH`, default 16: register/ALU width; legal range 16..64. The instruction is always 16 bits.
- `clk_50MHz` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `run` input, 1 bit: instruction request; `DIN` is valid in the same cycle.
- `DIN` input, 16 bits: instruction word.
- `done` output, 1 bit: one-cycle completion pulse.
- `busy` output, 1 bit: high while the FSM is not in IDLE.
- `illegal` output, 1 bit: pulses with `done` for opcode 111.
- `flag_z`, `flag_n`, `flag_c` output, 1 bit each: zero, negative and carry flags.
- `dbg_sel` input, 3 bits: register select for the debug port.
- `dbg_data` output, `DATA_WIDTH` bits: combinational `r[dbg_sel]`.

## Operation
- Encoding: `DIN[15:13]` is the opcode, `DIN[12]` is M (immediate mode), `DIN[11:9]` is X (destination and first operand).
  - M=1: `DIN[8:0]` is a 9-bit signed immediate, sign-extended to `DATA_WIDTH`.
  - M=0: `DIN[2:0]` is register Y; `DIN[8:3]` is ignored.
- Opcodes:
  - 000 mv: rX ← op2.
  - 001 mvt: rX ← {`DIN[7:0]`, zeros}, with the byte placed in the top 8 bits.
  - 010 add: rX ← rX + op2.
  - 011 sub: rX ← rX − op2, computed as rX + ~op2 + 1.
  - 100 and, 101 or, 110 xor.
  - 111 illegal: no register or flag write.
- Flags are written only by opcodes 010–110:
  - z = (result == 0).
  - n = result MSB.
  - c = carry out of bit `DATA_WIDTH`−1 for add/sub (sub: c=1 means no borrow); c=0 for logic ops.
- mv, mvt and illegal leave all flags unchanged.
- FSM states: IDLE, T1, T2, T3.
  - IDLE: if `run`, then IR ← DIN and go to T1; otherwise stay.
  - T1, mv/mvt: write rX, set done, go to IDLE.
  - T1, illegal: set done and illegal, go to IDLE.
  - T1, ALU op: A ← rX, B ← op2 (op2 is Y or the immediate), go to T2.
  - T2: G ← A op B and latch next flags, go to T3.
  - T3: rX ← G, commit flags, set done, go to IDLE.
- `run` while `busy` is ignored; the in-flight IR is unaffected.
- X == Y is legal and uses the pre-instruction value (e.g. sub r0,r0 gives 0).
- Arithmetic wraps modulo 2^`DATA_WIDTH`.

## Timing
- Reset values: r0–r7 = 0, IR/A/B/G = 0, FSM = IDLE, and `done`, `illegal`, `busy`, all flags = 0.
- `reset` mid-instruction: at that edge the FSM returns to IDLE with no register write and no `done`. Reset overrides `run` in the same cycle.
- Let E0 be the edge at which `run` is sampled in IDLE.
  - mv/mvt/illegal: write at E1; `done` high during cycle E1→E2.
  - ALU ops: write at E3; `done` high during E3→E4.
- `done` is registered, exactly one cycle wide, and coincides with the updated value on `dbg_data` and the flags.
- `busy` is high from E0+ until the edge that returns the FSM to IDLE.
- Back-to-back: `run` held or asserted during the `done` cycle is accepted at that edge (FSM already in IDLE). Throughput is 1 instruction per 2 cycles (mv) or per 4 cycles (ALU).

## Test plan
- Reset: assert `reset` 2 cycles with `run`=1 → `done`=0, `busy`=0, all flags 0, `dbg_data`=0 for every `dbg_sel`.
- W=16, negative+negative: 0x11FF (mv r0,#-1), 0x13FE (mv r1,#-2), 0x4001 (add r0,r1).
  - r0=0xFFFD, r1=0xFFFE, n=1, c=1, z=0.
  - `done` arrives 2/2/4 cycles after each accept.
- Sub and immediate add: 0x6000 (sub r0,r0) → r0=0, z=1, c=1. Then 0x5205 (add r1,#5) with r1=0 → r1=5, z=0, n=0, c=0.
- W=32: 0x17FF (mv r3,#-1) → r3=0xFFFFFFFF, flags unchanged. 0x34A5 (mvt r2,#0xA5) → r2=0xA5000000.
- Illegal and busy: 0xE000 → `illegal` and `done` pulse together after 2 cycles, no state change. `run` with 0x1001 during an add's T2 → ignored; r0 is unchanged by it.
- Reset mid-op: issue 0x4001, assert `reset` in T2 → r0=0, no `done`. Next `run` after reset executes normally.
